// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int LAT_W    = 3;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side signals of the arbiter, bundled for port use.
interface mem_arb_if #(
  parameter int ADDR_W = 20
);

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [31:0]       if_rdata_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [1:0]        d_size_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [31:0]       d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [31:0]       d_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [1:0]        mem_size_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  logic              busy_o;

  // The arbiter itself sits on the slave side.
  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_req_i, d_we_i, d_size_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_req_i, d_we_i, d_size_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  busy_o
  );

endinterface

// File: rtl/mem_arb_starve.sv
// Fetch starvation guard: counts back-to-back data grants while fetch waits
// and raises force_if once the limit is reached.
module mem_arb_starve
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_gnt,
  input  logic if_gnt,
  input  logic if_req,
  output logic force_if
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;

  // Saturates at the limit so a late-rising fetch request cannot wrap it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt) begin
      if (!if_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

  assign force_if = (starve_cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port arbiter between instruction fetch and load/store; data has priority.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic     clk,
  input  logic     rst,
  mem_arb_if.slave bus
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT);

  arb_state_t       state;
  arb_state_t       state_nxt;
  arb_owner_t       owner;
  logic             is_store;
  logic [LAT_W-1:0] lat_cnt;

  logic any_req;
  logic if_wins;
  logic force_if;
  logic last_wait;

  logic              mem_req_n;
  logic              mem_we_n;
  logic [1:0]        mem_size_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [31:0]       mem_wdata_n;
  logic              if_gnt_n;
  logic              d_gnt_n;
  logic              if_rvalid_n;
  logic              d_rvalid_n;
  logic              cap_if;
  logic              cap_d;
  logic              busy_n;

  assign any_req   = bus.d_req_i | bus.if_req_i;
  assign if_wins   = bus.if_req_i & (~bus.d_req_i | force_if);
  assign last_wait = (state == WAIT) && (lat_cnt == LAT_W'(1));

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .d_gnt   (bus.d_gnt_o),
    .if_gnt  (bus.if_gnt_o),
    .if_req  (bus.if_req_i),
    .force_if(force_if)
  );
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign force_if = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      is_store <= 1'b0;
      lat_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        owner    <= if_wins ? OWN_IF : OWN_D;
        is_store <= ~if_wins & bus.d_we_i;
      end
      if (state == ISSUE) begin
        lat_cnt <= LAT_INIT;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = is_store ? IDLE : WAIT;
      WAIT:    if (last_wait) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every output is registered, so this computes the values for the next cycle.
  always_comb begin
    mem_req_n   = 1'b0;
    mem_we_n    = 1'b0;
    mem_size_n  = SZ_BYTE;
    mem_addr_n  = '0;
    mem_wdata_n = '0;
    if_gnt_n    = 1'b0;
    d_gnt_n     = 1'b0;
    if_rvalid_n = 1'b0;
    d_rvalid_n  = 1'b0;
    cap_if      = 1'b0;
    cap_d       = 1'b0;
    busy_n      = (state_nxt != IDLE);

    if (state == IDLE && any_req) begin
      mem_req_n = 1'b1;
      if (if_wins) begin
        if_gnt_n   = 1'b1;
        mem_size_n = SZ_WORD;
        mem_addr_n = bus.if_addr_i;
      end else begin
        d_gnt_n     = 1'b1;
        mem_we_n    = bus.d_we_i;
        mem_size_n  = bus.d_size_i;
        mem_addr_n  = bus.d_addr_i;
        mem_wdata_n = bus.d_wdata_i;
      end
    end

    if (last_wait) begin
      if (owner == OWN_IF) begin
        if_rvalid_n = 1'b1;
        cap_if      = 1'b1;
      end else begin
        d_rvalid_n = 1'b1;
        cap_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_size_o  <= 2'b00;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      bus.if_gnt_o    <= 1'b0;
      bus.d_gnt_o     <= 1'b0;
      bus.if_rvalid_o <= 1'b0;
      bus.d_rvalid_o  <= 1'b0;
      bus.if_rdata_o  <= '0;
      bus.d_rdata_o   <= '0;
      bus.busy_o      <= 1'b0;
    end else begin
      bus.mem_req_o   <= mem_req_n;
      bus.mem_we_o    <= mem_we_n;
      bus.mem_size_o  <= mem_size_n;
      bus.mem_addr_o  <= mem_addr_n;
      bus.mem_wdata_o <= mem_wdata_n;
      bus.if_gnt_o    <= if_gnt_n;
      bus.d_gnt_o     <= d_gnt_n;
      bus.if_rvalid_o <= if_rvalid_n;
      bus.d_rvalid_o  <= d_rvalid_n;
      bus.busy_o      <= busy_n;
      if (cap_if) bus.if_rdata_o <= bus.mem_rdata_i;
      if (cap_d)  bus.d_rdata_o  <= bus.mem_rdata_i;
    end
  end

  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst)
    !(bus.if_gnt_o && bus.d_gnt_o));
  a_rvalid_onehot : assert property (@(posedge clk) disable iff (rst)
    !(bus.if_rvalid_o && bus.d_rvalid_o));

endmodule
